// File: rtl/inv_key_scheduler.sv
// AES-128 inverse key schedule: starting from the round-10 key, presents
// round keys 10 down to 0, one per cycle, using an external S-box array.
module inv_key_scheduler (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] last_key,
    output logic [31:0]  sub_in,
    input  logic [31:0]  sub_out,
    output logic [127:0] rk,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e       state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rk_round_q, rk_round_d;
    logic         rk_valid_q, rk_valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rcon;

    assign w0 = rk_q[127:96];
    assign w1 = rk_q[95:64];
    assign w2 = rk_q[63:32];
    assign w3 = rk_q[31:0];
    // t is w3 of the previous round key, so RotWord(t) feeds the S-box.
    assign t      = w3 ^ w2;
    assign sub_in = {t[23:0], t[31:24]};

    always_comb begin
        unique case (rk_round_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rk_d       = rk_q;
        rk_round_d = rk_round_q;
        rk_valid_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    rk_d       = last_key;
                    rk_round_d = 4'd10;
                    rk_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = StRun;
                end
            end
            StRun: begin
                if (rk_round_q != 4'd0) begin
                    rk_d       = {w0 ^ sub_out ^ {rcon, 24'h0}, w1 ^ w0, w2 ^ w1, t};
                    rk_round_d = rk_round_q - 4'd1;
                    rk_valid_d = 1'b1;
                    busy_d     = 1'b1;
                end else begin
                    done_d  = 1'b1;
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rk_q       <= 128'h0;
            rk_round_q <= 4'd0;
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rk_q       <= rk_d;
            rk_round_q <= rk_round_d;
            rk_valid_q <= rk_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rk       = rk_q;
    assign rk_round = rk_round_q;
    assign rk_valid = rk_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_inv_key_scheduler.sv
// Bench for inv_key_scheduler: S-box and forward key expansion built from
// GF(2^8) arithmetic, directed table vectors, protocol corners, random round trips.
module tb_inv_key_scheduler;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] last_key;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox [256];
    logic [127:0] fwd [11];

    inv_key_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .last_key (last_key),
        .sub_in   (sub_in),
        .sub_out  (sub_out),
        .rk       (rk),
        .rk_round (rk_round),
        .rk_valid (rk_valid),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sub_out = {sbox[sub_in[31:24]], sbox[sub_in[23:16]],
                      sbox[sub_in[15:8]],  sbox[sub_in[7:0]]};

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(a[7:0], b[7:0]) == 8'h01) inv = b[7:0];
            sbox[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                      {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    // Standard forward expansion of a round-0 key into fwd[0..10].
    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) fwd[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Runs one expansion of fwd[10] and checks every cycle against fwd[].
    // mode 0: plain, 1: extra start pulse mid-run, 2: start left high throughout.
    task automatic run_seq(input int mode, input logic chk_sub, input logic [31:0] exp_sub,
                           input logic chk_r9, input logic [127:0] exp_r9);
        last_key = fwd[10];
        start    = 1'b1;
        @(negedge clk);
        if (mode != 2) begin
            start    = 1'b0;
            last_key = ~fwd[10];
        end
        for (int k = 10; k >= 0; k--) begin
            if (mode == 1) begin
                start    = (k == 6);
                last_key = {$urandom, $urandom, $urandom, $urandom};
            end
            check("run_flags", {125'h0, rk_valid, busy, done}, 128'b110);
            check("run_round", {124'h0, rk_round}, k);
            check("run_key", rk, fwd[k]);
            if (k == 10 && chk_sub) check("sub_in_r10", {96'h0, sub_in}, {96'h0, exp_sub});
            if (k == 9 && chk_r9) check("table_r9", rk, exp_r9);
            @(negedge clk);
        end
        if (mode == 1) start = 1'b0;
        check("fin_flags", {125'h0, rk_valid, busy, done}, 128'b001);
        check("fin_round", {124'h0, rk_round}, 128'h0);
        check("fin_key", rk, fwd[0]);
        @(negedge clk);
        check("idle_flags", {125'h0, rk_valid, busy, done}, 128'b000);
        check("idle_hold", {rk[127:4], rk_round}, {fwd[0][127:4], 4'd0});
    endtask

    typedef struct {
        logic [127:0] exp_r0;
        logic [127:0] last_key;
        logic [31:0]  exp_sub;
        logic         chk_r9;
        logic [127:0] exp_r9;
    } vec_t;

    vec_t vecs [2];
    logic saw;

    initial begin
        vecs[0] = '{exp_r0:   128'h2b7e151628aed2a6abf7158809cf4f3c,
                    last_key: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                    exp_sub:  32'h5c006e57, chk_r9: 1'b1,
                    exp_r9:   128'hac7766f319fadc2128d12941575c006e};
        vecs[1] = '{exp_r0:   128'h0,
                    last_key: 128'hb4ef5bcb3e92e21123e951cf6f8f188e,
                    exp_sub:  32'h6649414c, chk_r9: 1'b0, exp_r9: 128'h0};

        rst      = 1'b1;
        start    = 1'b0;
        last_key = 128'h0;
        build_sbox();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {rk[127:8], rk_round, rk_valid, busy, done, 1'b0}, 128'h0);
        rst = 1'b0;
        last_key = 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_start_idle", {rk[127:8], rk_round, rk_valid, busy, done, 1'b0}, 128'h0);
        end

        // Directed table: table key must match the model's round 10 and the DUT walk.
        foreach (vecs[i]) begin
            expand(vecs[i].exp_r0);
            check("table_model_r10", fwd[10], vecs[i].last_key);
            run_seq(0, 1'b1, vecs[i].exp_sub, vecs[i].chk_r9, vecs[i].exp_r9);
        end

        // Restart FIPS key for the protocol corners.
        expand(vecs[0].exp_r0);
        run_seq(1, 1'b0, 32'h0, 1'b0, 128'h0);

        // start held high: FIN ignores it, next IDLE accepts it.
        run_seq(2, 1'b0, 32'h0, 1'b0, 128'h0);
        run_seq(0, 1'b0, 32'h0, 1'b0, 128'h0);

        // rst and start together: start dropped.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_outs", {rk[127:8], rk_round, rk_valid, busy, done, 1'b0}, 128'h0);
        @(negedge clk);
        check("rst_start_idle", {125'h0, rk_valid, busy, done}, 128'h0);

        // Mid-run reset at N+5: aborts, no done.
        last_key = fwd[10];
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_abort_round", {124'h0, rk_round}, 128'd7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outs", {rk[127:8], rk_round, rk_valid, busy, done, 1'b0}, 128'h0);
        saw = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (done || rk_valid || busy) saw = 1'b1;
        end
        check("abort_quiet", {127'h0, saw}, 128'h0);
        run_seq(0, 1'b1, 32'h5c006e57, 1'b1, 128'hac7766f319fadc2128d12941575c006e);

        // Round trip on random keys.
        for (int n = 0; n < 100; n++) begin
            expand({$urandom, $urandom, $urandom, $urandom});
            run_seq(0, 1'b0, 32'h0, 1'b0, 128'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
